// File: rtl/palette_pkg.sv
// Shared types and constants for the palette loader: FSM states, CSR word
// addresses, CTRL/STATUS bit positions and the CONF count decode.
package palette_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_VS,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [1:0] CSR_SRC    = 2'd0;
    localparam logic [1:0] CSR_CONF   = 2'd1;
    localparam logic [1:0] CSR_CTRL   = 2'd2;
    localparam logic [1:0] CSR_STATUS = 2'd3;

    localparam int CTRL_START      = 0;
    localparam int CTRL_WAIT_VSYNC = 1;
    localparam int CTRL_IRQ_EN     = 2;
    localparam int CTRL_ABORT      = 3;

    localparam int STAT_BUSY        = 0;
    localparam int STAT_DONE        = 1;
    localparam int STAT_ABORTED     = 2;
    localparam int STAT_ENTRIES_LSB = 4;

    localparam int CONF_COUNT_LSB = 8;

    // A count field of zero means a full 256-entry table.
    function automatic logic [8:0] decode_count(input logic [8:0] raw);
        return (raw == 9'd0) ? 9'd256 : raw;
    endfunction

endpackage

// File: rtl/palette_loader_csr.sv
// CSR register file for the palette loader: SRC/CONF storage, sticky irq_en,
// W1C done/aborted flags, start/abort pulses and registered read data.
module palette_loader_csr
    import palette_pkg::*;
#(
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        i_address,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [31:0]       i_writedata,
    output logic [31:0]       o_readdata,
    input  logic              i_busy,
    input  logic              i_job_start,
    input  logic              i_done_set,
    input  logic              i_aborted_set,
    input  logic [7:0]        i_entries,
    output logic [ADDR_W-1:0] o_src,
    output logic [7:0]        o_first,
    output logic [8:0]        o_count,
    output logic              o_start,
    output logic              o_abort,
    output logic              o_wait_vsync,
    output logic              o_irq
);

    logic [ADDR_W-1:0] r_src;
    logic [16:0]       r_conf;
    logic              r_irq_en;
    logic              r_done;
    logic              r_aborted;
    logic [31:0]       r_readdata;

    logic        w_ctrl_wr;
    logic        w_stat_wr;
    logic [31:0] w_rd_mux;
    logic        w_unused_wdata;

    assign w_ctrl_wr = i_write && (i_address == CSR_CTRL);
    assign w_stat_wr = i_write && (i_address == CSR_STATUS);

    // Command bits act in the cycle of the CTRL write; the FSM decides if they apply.
    assign o_start      = w_ctrl_wr && i_writedata[CTRL_START];
    assign o_abort      = w_ctrl_wr && i_writedata[CTRL_ABORT];
    assign o_wait_vsync = i_writedata[CTRL_WAIT_VSYNC];

    assign o_src        = r_src;
    assign o_first      = r_conf[7:0];
    assign o_count      = decode_count(r_conf[16:CONF_COUNT_LSB]);
    assign o_irq        = r_done && r_irq_en;
    assign o_readdata   = r_readdata;

    // Upper write-data bits have no home in any register.
    assign w_unused_wdata = ^i_writedata;

    // Read-data mux for the addressed CSR word.
    always_comb begin
        // NOTE: defaulting the output before the case keeps this from inferring a latch.
        w_rd_mux = '0;
        case (i_address)
            CSR_SRC:    w_rd_mux[ADDR_W-1:0] = r_src;
            CSR_CONF:   w_rd_mux[16:0]       = r_conf;
            CSR_CTRL:   w_rd_mux[CTRL_IRQ_EN] = r_irq_en;
            CSR_STATUS: begin
                w_rd_mux[STAT_BUSY]               = i_busy;
                w_rd_mux[STAT_DONE]               = r_done;
                w_rd_mux[STAT_ABORTED]            = r_aborted;
                w_rd_mux[STAT_ENTRIES_LSB +: 8]   = i_entries;
            end
            default:    w_rd_mux = '0;
        endcase
    end

    // Register writes, W1C status flags and the one-cycle-latency read port.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (reset) begin
            r_src      <= '0;
            r_conf     <= '0;
            r_irq_en   <= 1'b0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
            r_readdata <= '0;
        end else begin
            if (i_write && (i_address == CSR_SRC))
                r_src <= {i_writedata[ADDR_W-1:1], 1'b0};
            if (i_write && (i_address == CSR_CONF))
                r_conf <= i_writedata[16:0];
            if (w_ctrl_wr)
                r_irq_en <= i_writedata[CTRL_IRQ_EN];

            if (i_done_set)
                r_done <= 1'b1;
            else if (i_job_start || (w_stat_wr && i_writedata[STAT_DONE]))
                r_done <= 1'b0;

            if (i_aborted_set)
                r_aborted <= 1'b1;
            else if (i_job_start || (w_stat_wr && i_writedata[STAT_ABORTED]))
                r_aborted <= 1'b0;

            if (i_read)
                r_readdata <= w_rd_mux;
        end
    end

endmodule

// File: rtl/palette_loader.sv
// Palette refill DMA: optional vsync-aligned start, pipelined 16-bit Avalon
// reads with a bounded number in flight, and one palette write per return.
module palette_loader
    import palette_pkg::*;
#(
    parameter int ADDR_W          = 24,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        avs_ctrl_address,
    input  logic              avs_ctrl_read,
    input  logic              avs_ctrl_write,
    input  logic [31:0]       avs_ctrl_writedata,
    output logic [31:0]       avs_ctrl_readdata,
    output logic              avm_master_read,
    output logic [ADDR_W-1:0] avm_master_address,
    input  logic [15:0]       avm_master_readdata,
    input  logic              avm_master_readdatavalid,
    input  logic              avm_master_waitrequest,
    output logic [7:0]        pal_address,
    output logic [15:0]       pal_writedata,
    output logic              pal_write,
    input  logic              vsync,
    output logic              irq
);

    localparam int              OUT_W   = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [8:0]        r_issued;
    logic [8:0]        r_count;
    logic [OUT_W-1:0]  r_outstanding;
    logic [7:0]        r_wr_idx;
    logic [7:0]        r_entries;
    logic              r_abort_flag;
    logic              r_vsync_d;
    logic              r_pal_write;
    logic [7:0]        r_pal_address;
    logic [15:0]       r_pal_writedata;

    logic [ADDR_W-1:0] w_src;
    logic [7:0]        w_first;
    logic [8:0]        w_count;
    logic              w_start;
    logic              w_abort;
    logic              w_wait_vsync;
    logic              w_job_start;
    logic              w_busy;
    logic              w_accept;
    logic              w_rsp;
    logic              w_vsync_rise;
    logic              w_abortable;

    palette_loader_csr #(.ADDR_W(ADDR_W)) u_csr (
        .clk           (clk),
        .reset         (reset),
        .i_address     (avs_ctrl_address),
        .i_read        (avs_ctrl_read),
        .i_write       (avs_ctrl_write),
        .i_writedata   (avs_ctrl_writedata),
        .o_readdata    (avs_ctrl_readdata),
        .i_busy        (w_busy),
        .i_job_start   (w_job_start),
        .i_done_set    (r_state == ST_DONE),
        .i_aborted_set ((r_state == ST_DONE) && r_abort_flag),
        .i_entries     (r_entries),
        .o_src         (w_src),
        .o_first       (w_first),
        .o_count       (w_count),
        .o_start       (w_start),
        .o_abort       (w_abort),
        .o_wait_vsync  (w_wait_vsync),
        .o_irq         (irq)
    );

    assign w_job_start  = w_start && (r_state == ST_IDLE);
    assign w_busy       = (r_state != ST_IDLE);
    assign w_abortable  = (r_state == ST_WAIT_VS) || (r_state == ST_FETCH);
    assign w_vsync_rise = vsync && !r_vsync_d;

    // Read request depends only on registers, so it cannot move under waitrequest.
    assign avm_master_read    = (r_state == ST_FETCH) && (r_issued < r_count) &&
                                (r_outstanding < MAX_OUT);
    assign avm_master_address = r_addr;
    assign w_accept           = avm_master_read && !avm_master_waitrequest;
    // Responses with nothing in flight are stale (e.g. after a reset) and are dropped.
    assign w_rsp              = avm_master_readdatavalid && (r_outstanding != '0);

    assign pal_write     = r_pal_write;
    assign pal_address   = r_pal_address;
    assign pal_writedata = r_pal_writedata;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // FSM next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (w_start) w_next_state = w_wait_vsync ? ST_WAIT_VS : ST_FETCH;
            ST_WAIT_VS: begin
                if (w_abort)           w_next_state = ST_DONE;
                else if (w_vsync_rise) w_next_state = ST_FETCH;
            end
            ST_FETCH:   if (w_abort || (r_issued == r_count)) w_next_state = ST_DRAIN;
            ST_DRAIN:   if (r_outstanding == '0) w_next_state = ST_DONE;
            ST_DONE:    w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // Job counters, in-flight tracking and the registered palette write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr          <= '0;
            r_issued        <= '0;
            r_count         <= '0;
            r_outstanding   <= '0;
            r_wr_idx        <= '0;
            r_entries       <= '0;
            r_abort_flag    <= 1'b0;
            r_vsync_d       <= 1'b0;
            r_pal_write     <= 1'b0;
            r_pal_address   <= '0;
            r_pal_writedata <= '0;
        end else begin
            r_vsync_d <= vsync;

            if (w_job_start) begin
                r_addr       <= w_src;
                r_count      <= w_count;
                r_issued     <= '0;
                r_wr_idx     <= w_first;
                r_entries    <= '0;
                r_abort_flag <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_addr   <= r_addr + ADDR_W'(2);
                    r_issued <= r_issued + 9'd1;
                end
                if (w_abort && w_abortable)
                    r_abort_flag <= 1'b1;
                if (w_rsp) begin
                    r_wr_idx  <= r_wr_idx + 8'd1;
                    r_entries <= r_entries + 8'd1;
                end
            end

            case ({w_accept, w_rsp})
                2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase

            r_pal_write <= w_rsp;
            if (w_rsp) begin
                r_pal_address   <= r_wr_idx;
                r_pal_writedata <= avm_master_readdata;
            end
        end
    end

endmodule

// File: tb/tb_palette_loader.sv
// Self-checking bench for palette_loader: an Avalon memory responder with
// configurable latency/stalls, and scoreboards of expected read addresses and
// palette writes that are filled when a job is started.
module tb_palette_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  avs_ctrl_address = '0;
    logic        avs_ctrl_read = 1'b0;
    logic        avs_ctrl_write = 1'b0;
    logic [31:0] avs_ctrl_writedata = '0;
    logic [31:0] avs_ctrl_readdata;
    logic        avm_master_read;
    logic [23:0] avm_master_address;
    logic [15:0] avm_master_readdata = '0;
    logic        avm_master_readdatavalid = 1'b0;
    logic        avm_master_waitrequest = 1'b0;
    logic [7:0]  pal_address;
    logic [15:0] pal_writedata;
    logic        pal_write;
    logic        vsync = 1'b0;
    logic        irq;

    palette_loader #(.ADDR_W(24), .MAX_OUTSTANDING(4)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .avs_ctrl_address         (avs_ctrl_address),
        .avs_ctrl_read            (avs_ctrl_read),
        .avs_ctrl_write           (avs_ctrl_write),
        .avs_ctrl_writedata       (avs_ctrl_writedata),
        .avs_ctrl_readdata        (avs_ctrl_readdata),
        .avm_master_read          (avm_master_read),
        .avm_master_address       (avm_master_address),
        .avm_master_readdata      (avm_master_readdata),
        .avm_master_readdatavalid (avm_master_readdatavalid),
        .avm_master_waitrequest   (avm_master_waitrequest),
        .pal_address              (pal_address),
        .pal_writedata            (pal_writedata),
        .pal_write                (pal_write),
        .vsync                    (vsync),
        .irq                      (irq)
    );

    always #5 clk = ~clk;

    int tb_cyc = 0;
    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    typedef struct {
        logic [15:0] data;
        int          due;
    } rsp_t;

    int total = 0;
    int bad   = 0;

    logic [23:0] exp_q[$];     // expected palette writes {index, data}
    logic [23:0] exp_rd_q[$];  // expected master read addresses
    rsp_t        pend_q[$];

    int lat       = 2;
    bit rand_wait = 1'b0;
    int acc_limit = 1000000;
    bit stab_en   = 1'b1;

    int acc_cnt = 0, ret_cnt = 0, out_cnt = 0, max_out = 0, stab_err = 0;
    int first_read_cyc = -1, wr_cnt = 0;

    bit          wr_now, prev_stall = 1'b0;
    logic [23:0] prev_addr = '0;
    logic [23:0] rd_exp;
    logic [23:0] mon_e;
    rsp_t        rsp_new, rsp_head;

    function automatic logic [15:0] mem_word(input logic [23:0] a);
        logic [15:0] m;
        m = a[15:0] * 16'd7;
        return m ^ 16'hA55A ^ {8'h00, a[23:16]};
    endfunction

    // Avalon memory responder: picks waitrequest, returns data in order after lat cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (stab_en && prev_stall &&
                (!avm_master_read || avm_master_address !== prev_addr))
                stab_err++;
            wr_now = (acc_cnt >= acc_limit) || (rand_wait && ($urandom_range(0, 2) == 0));
            avm_master_waitrequest = wr_now;
            if (pend_q.size() != 0 && pend_q[0].due <= tb_cyc) begin
                rsp_head = pend_q.pop_front();
                avm_master_readdatavalid = 1'b1;
                avm_master_readdata      = rsp_head.data;
                ret_cnt++;
                out_cnt--;
            end else begin
                avm_master_readdatavalid = 1'b0;
                avm_master_readdata      = 16'h0000;
            end
            if (avm_master_read && !wr_now) begin
                rsp_new.data = mem_word(avm_master_address);
                rsp_new.due  = tb_cyc + lat;
                pend_q.push_back(rsp_new);
                acc_cnt++;
                out_cnt++;
                total++;
                if (exp_rd_q.size() == 0) begin
                    bad++;
                    $display("FAIL read_addr: got unexpected read at %h, want no read", avm_master_address);
                end else begin
                    rd_exp = exp_rd_q.pop_front();
                    if (avm_master_address !== rd_exp) begin
                        bad++;
                        $display("FAIL read_addr: got %h, want %h", avm_master_address, rd_exp);
                    end
                end
            end
            if (out_cnt > max_out) max_out = out_cnt;
            prev_stall = avm_master_read && wr_now;
            prev_addr  = avm_master_address;
            if (avm_master_read && first_read_cyc < 0) first_read_cyc = tb_cyc;
        end
    end

    // Palette write monitor: pops the scoreboard on every pal_write.
    initial begin
        forever begin
            @(negedge clk);
            if (pal_write === 1'b1) begin
                wr_cnt++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL pal_write: got idx=%0d data=%h, want no write", pal_address, pal_writedata);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({pal_address, pal_writedata} !== mon_e) begin
                        bad++;
                        $display("FAIL pal_write: got idx=%0d data=%h, want idx=%0d data=%h",
                                 pal_address, pal_writedata, mon_e[23:16], mon_e[15:0]);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_ctrl_address   = a;
        avs_ctrl_writedata = d;
        avs_ctrl_write     = 1'b1;
        @(negedge clk);
        avs_ctrl_write     = 1'b0;
    endtask

    task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_ctrl_address = a;
        avs_ctrl_read    = 1'b1;
        @(negedge clk);
        avs_ctrl_read    = 1'b0;
        d = avs_ctrl_readdata;
    endtask

    task automatic wait_idle(input string name);
        logic [31:0] s;
        int n;
        n = 0;
        do begin
            csr_read(2'd3, s);
            n++;
        end while (s[0] && n < 3000);
        if (s[0] !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: busy=%b after %0d polls, want 0", name, s[0], n);
        end
    endtask

    // Fills the scoreboards from the job parameters, then programs and starts the job.
    task automatic start_job(input logic [23:0] src, input logic [7:0] first,
                             input logic [8:0] cnt_field, input logic [31:0] ctrl);
        int n;
        logic [23:0] a;
        logic [7:0]  idx;
        n = (cnt_field == 9'd0) ? 256 : int'(cnt_field);
        for (int i = 0; i < n; i++) begin
            a   = src + 24'(2 * i);
            idx = first + 8'(i);
            exp_rd_q.push_back(a);
            exp_q.push_back({idx, mem_word(a)});
        end
        acc_cnt = 0;
        wr_cnt = 0;
        stab_err = 0;
        max_out = out_cnt;
        first_read_cyc = -1;
        csr_write(2'd0, {8'h00, src});
        csr_write(2'd1, {15'd0, cnt_field, first});
        csr_write(2'd2, ctrl);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({avm_master_read, avm_master_address, pal_write, pal_address, pal_writedata, irq,
             avs_ctrl_readdata} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got read=%b addr=%h pw=%b pa=%h pd=%h irq=%b rd=%h, want all 0",
                     avm_master_read, avm_master_address, pal_write, pal_address, pal_writedata,
                     irq, avs_ctrl_readdata);
        end
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            csr_read(2'(a), d);
            total++;
            if (d !== 32'h0) begin
                bad++;
                $display("FAIL reset_csr%0d: got %h, want 00000000", a, d);
            end
        end
    endtask

    task automatic test_basic;
        logic [31:0] d;
        lat = 2;
        start_job(24'h001000, 8'd0, 9'd16, 32'h5);
        wait_idle("basic");
        total++;
        if (exp_q.size() != 0 || exp_rd_q.size() != 0) begin
            bad++;
            $display("FAIL basic_count: got %0d writes, %0d reads missing, want 0 missing",
                     exp_q.size(), exp_rd_q.size());
        end
        csr_read(2'd3, d);
        total++;
        if (d !== 32'h102) begin
            bad++;
            $display("FAIL basic_status: got %h, want 00000102", d);
        end
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL basic_irq: got %b, want 1", irq);
        end
        csr_read(2'd2, d);
        total++;
        if (d !== 32'h4) begin
            bad++;
            $display("FAIL basic_irq_en_rd: got %h, want 00000004", d);
        end
        csr_write(2'd3, 32'h2);
        csr_read(2'd3, d);
        total++;
        if (d !== 32'h100 || irq !== 1'b0) begin
            bad++;
            $display("FAIL basic_w1c: got status=%h irq=%b, want 00000100 irq=0", d, irq);
        end
    endtask

    task automatic test_wait_vsync;
        logic [31:0] d;
        int e;
        vsync = 1'b1;
        repeat (4) @(negedge clk);
        lat = 2;
        start_job(24'h002000, 8'd5, 9'd4, 32'h3);
        repeat (10) @(negedge clk);
        total++;
        if (first_read_cyc != -1 || acc_cnt != 0) begin
            bad++;
            $display("FAIL vsync_hold: got first read at cycle %0d (%0d accepted), want none",
                     first_read_cyc, acc_cnt);
        end
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        vsync = 1'b1;
        e = tb_cyc;
        wait_idle("vsync");
        total++;
        if (first_read_cyc != e + 1) begin
            bad++;
            $display("FAIL vsync_latency: got first read at cycle %0d, want %0d", first_read_cyc, e + 1);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL vsync_count: got %0d writes missing, want 0", exp_q.size());
        end
        csr_read(2'd3, d);
        total++;
        if (d !== 32'h42 || irq !== 1'b0) begin
            bad++;
            $display("FAIL vsync_status: got %h irq=%b, want 00000042 irq=0", d, irq);
        end
    endtask

    task automatic test_random_wait;
        logic [31:0] d;
        lat = 6;
        rand_wait = 1'b1;
        start_job(24'h020000, 8'd0, 9'd0, 32'h1);
        wait_idle("random");
        rand_wait = 1'b0;
        total++;
        if (max_out != 4) begin
            bad++;
            $display("FAIL random_outstanding: got max %0d in flight, want 4", max_out);
        end
        total++;
        if (stab_err != 0) begin
            bad++;
            $display("FAIL random_stable: got %0d read/address changes under waitrequest, want 0", stab_err);
        end
        total++;
        if (acc_cnt != 256 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL random_count: got %0d reads, %0d writes missing, want 256 and 0",
                     acc_cnt, exp_q.size());
        end
        csr_read(2'd3, d);
        total++;
        if (d !== 32'h002) begin
            bad++;
            $display("FAIL random_status: got %h, want 00000002", d);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] d;
        lat = 2;
        start_job(24'h003000, 8'd250, 9'd10, 32'h9);
        wait_idle("wrap");
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL wrap_count: got %0d writes missing, want 0", exp_q.size());
        end
        csr_read(2'd3, d);
        total++;
        if (d !== 32'hA2) begin
            bad++;
            $display("FAIL wrap_status: got %h, want 000000a2", d);
        end
        csr_write(2'd2, 32'h8);
        csr_read(2'd3, d);
        total++;
        if (d !== 32'hA2) begin
            bad++;
            $display("FAIL idle_abort: got %h, want 000000a2", d);
        end
    endtask

    task automatic test_abort;
        logic [31:0] d;
        lat = 3;
        acc_limit = 5;
        stab_en = 1'b0;
        start_job(24'h004000, 8'd0, 9'd20, 32'h1);
        for (int i = 0; i < 200 && acc_cnt < 5; i++) @(negedge clk);
        total++;
        if (acc_cnt != 5) begin
            bad++;
            $display("FAIL abort_setup: got %0d accepted reads, want 5", acc_cnt);
        end
        csr_write(2'd2, 32'h8);
        wait_idle("abort");
        total++;
        if (wr_cnt != 5 || exp_q.size() != 15) begin
            bad++;
            $display("FAIL abort_writes: got %0d writes (%0d left), want 5 (15 left)", wr_cnt, exp_q.size());
        end
        csr_read(2'd3, d);
        total++;
        if (d !== 32'h56) begin
            bad++;
            $display("FAIL abort_status: got %h, want 00000056", d);
        end
        exp_q.delete();
        exp_rd_q.delete();
        acc_limit = 1000000;
        stab_en = 1'b1;
    endtask

    task automatic test_reset_midjob;
        logic [31:0] d;
        int r0;
        lat = 6;
        start_job(24'h005000, 8'd0, 9'd16, 32'h5);
        for (int i = 0; i < 200 && acc_cnt < 3; i++) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        exp_rd_q.delete();
        wr_cnt = 0;
        r0 = ret_cnt;
        total++;
        if ({avm_master_read, avm_master_address, pal_write, pal_address, pal_writedata, irq} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs: got read=%b addr=%h pw=%b pa=%h pd=%h irq=%b, want all 0",
                     avm_master_read, avm_master_address, pal_write, pal_address, pal_writedata, irq);
        end
        reset = 1'b0;
        for (int i = 0; i < 60 && pend_q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        total++;
        if (ret_cnt - r0 < 2 || wr_cnt != 0) begin
            bad++;
            $display("FAIL midreset_stale: got %0d pal_writes from %0d stale returns, want 0 from >=2",
                     wr_cnt, ret_cnt - r0);
        end
        csr_read(2'd3, d);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL midreset_status: got %h, want 00000000", d);
        end
        csr_read(2'd0, d);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL midreset_src: got %h, want 00000000", d);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_vsync();
        test_random_wait();
        test_wrap();
        test_abort();
        test_reset_midjob();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
